// File: rtl/fifo_mem_responder_pkg.sv
// Request/response word layout and FSM state codes shared
// by the FIFO-to-memory responder and its RAM.
package fifo_mem_responder_pkg;

  localparam int REQ_W  = 41;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int OP_BIT = 40;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // op at [40], address at [39:16], data at [15:0]
  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM, one-cycle read latency.
// Contents are never reset.
module sp_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_mem_responder.sv
// Pops requests from a show-ahead FIFO, emulates DRAM access
// latency against a local RAM, and pushes one response per request.
module fifo_mem_responder
  import fifo_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic             clk_48,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] fifo_to_dram_data,
  input  logic             fifo_to_dram_empty_flag,
  output logic             fifo_to_dram_read_flag,
  output logic [REQ_W-1:0] fifo_from_dram_data,
  input  logic             fifo_from_dram_full_flag,
  output logic             fifo_from_dram_write_flag,
  output logic [3:0]       state_out,
  output logic [15:0]      resp_count
);

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t      r_state, w_state;
  logic [3:0]  r_cnt, w_cnt;
  req_t        r_req, w_req;
  req_t        r_resp, w_resp;
  logic        r_rd, w_rd;
  logic        r_wr, w_wr;
  logic [15:0] r_count, w_count;
  logic        r_started;
  logic        w_ram_en;
  logic [DATA_W-1:0] w_ram_rdata;

  sp_ram #(
    .AW (ADDR_BITS),
    .DW (DATA_W)
  ) u_ram (
    .i_clk   (clk_48),
    .i_en    (w_ram_en),
    .i_we    (r_req.op),
    .i_addr  (r_req.addr[ADDR_BITS-1:0]),
    .i_wdata (r_req.data),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_req    = r_req;
    w_resp   = r_resp;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    w_count  = r_count;
    w_ram_en = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // r_started holds off the first pop one edge past reset release
        if (r_started && !fifo_to_dram_empty_flag) begin
          w_req   = req_t'(fifo_to_dram_data);
          w_rd    = 1'b1;
          w_cnt   = LAT4;
          w_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state = S_ACCESS;
        else               w_cnt   = r_cnt - 4'd1;
      end
      S_ACCESS: begin
        w_ram_en = 1'b1;
        w_state  = S_RESP;
      end
      S_RESP: begin
        if (!fifo_from_dram_full_flag) begin
          w_resp.op   = r_req.op;
          w_resp.addr = r_req.addr;
          w_resp.data = r_req.op ? r_req.data : w_ram_rdata;
          w_wr        = 1'b1;
          w_count     = r_count + 16'd1;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_req     <= '0;
      r_resp    <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_count   <= 16'd0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_req     <= w_req;
      r_resp    <= w_resp;
      r_rd      <= w_rd;
      r_wr      <= w_wr;
      r_count   <= w_count;
      r_started <= 1'b1;
    end
  end

  assign fifo_to_dram_read_flag    = r_rd;
  assign fifo_from_dram_write_flag = r_wr;
  assign fifo_from_dram_data       = r_resp;
  assign state_out                 = {2'b00, r_state};
  assign resp_count                = r_count;

endmodule

// File: tb/tb_fifo_mem_responder.sv
// Self-checking bench: queue-based request FIFO, random response
// back-pressure, and a transaction-level model of the responder.
module tb_fifo_mem_responder;

  localparam int L  = 3;
  localparam int AB = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [40:0] req_data = '0;
  logic        empty = 1'b1;
  logic        rd;
  logic [40:0] resp;
  logic        full = 1'b0;
  logic        wr;
  logic [3:0]  st;
  logic [15:0] cnt;

  fifo_mem_responder #(
    .ADDR_BITS (AB),
    .LATENCY   (L)
  ) dut (
    .clk_48                    (clk),
    .rst_n                     (rst_n),
    .fifo_to_dram_data         (req_data),
    .fifo_to_dram_empty_flag   (empty),
    .fifo_to_dram_read_flag    (rd),
    .fifo_from_dram_data       (resp),
    .fifo_from_dram_full_flag  (full),
    .fifo_from_dram_write_flag (wr),
    .state_out                 (st),
    .resp_count                (cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [40:0] reqq[$];
  logic [15:0] mem[int];
  bit          gen_known[32];
  bit          inflight = 1'b0;
  int          pop_edge = 0;
  int          first_allowed = 0;
  logic [40:0] exp_resp = '0;
  logic [40:0] exp_data = '0;
  logic [15:0] exp_cnt = '0;
  bit          drv_empty = 1'b1;
  bit          drv_full = 1'b0;
  int          full_mode = 0;
  logic [40:0] dut_log[$];
  int          pop_log[$];
  int          push_log[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [40:0] mk(bit op, logic [23:0] a, logic [15:0] d);
    return {op, a, d};
  endfunction

  // One cycle: check outputs of the last rising edge, then drive inputs.
  task automatic tick();
    bit erf, ewf;
    logic [40:0] r;
    int d, idx, es;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk("rst_read_flag", 64'(rd), 64'(0));
      chk("rst_write_flag", 64'(wr), 64'(0));
      chk("rst_state", 64'(st), 64'(0));
      chk("rst_count", 64'(cnt), 64'(0));
      chk("rst_data", 64'(resp), 64'(0));
    end else begin
      erf = !inflight && !drv_empty && (cyc >= first_allowed);
      ewf = inflight && (cyc >= pop_edge + L + 3) && !drv_full;
      chk("read_flag", 64'(rd), 64'(erf));
      chk("write_flag", 64'(wr), 64'(ewf));
      if (wr) dut_log.push_back(resp);
      if (erf) begin
        r = reqq.pop_front();
        idx = int'(r[16 +: AB]);
        inflight = 1'b1;
        pop_edge = cyc;
        pop_log.push_back(cyc);
        if (r[40]) begin
          mem[idx] = r[15:0];
          exp_resp = r;
        end else begin
          exp_resp = {r[40:16], mem[idx]};
        end
      end
      if (ewf) begin
        inflight = 1'b0;
        exp_data = exp_resp;
        exp_cnt++;
        push_log.push_back(cyc);
      end
      d = cyc - pop_edge;
      es = !inflight ? 0 : (d <= L) ? 1 : (d == L + 1) ? 2 : 3;
      chk("state_out", 64'(st), 64'(es));
      chk("resp_count", 64'(cnt), 64'(exp_cnt));
      chk("resp_data", 64'(resp), 64'(exp_data));
    end
    drv_empty = (reqq.size() == 0);
    req_data  = drv_empty ? '0 : reqq[0];
    empty     = drv_empty;
    drv_full  = (full_mode == 2) ? ($urandom_range(0, 9) < 3) : (full_mode == 1);
    full      = drv_full;
  endtask

  task automatic drain(int bound);
    int n = 0;
    while ((reqq.size() != 0 || inflight) && n < bound) begin
      tick();
      n++;
    end
    if (reqq.size() != 0 || inflight) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout cyc=%0d actual=busy required=idle", cyc);
    end
    tick();
  endtask

  initial begin
    logic [40:0] last;
    int n0, c0, n;
    bit op;
    int idx;
    logic [31:0] hi;

    repeat (3) tick();
    rst_n = 1'b1;
    first_allowed = cyc + 2;

    // writes 0..3 with data = address, then reads back
    for (int i = 0; i < 4; i++) reqq.push_back(mk(1'b1, 24'(i), 16'(i)));
    for (int i = 0; i < 4; i++) reqq.push_back(mk(1'b0, 24'(i), 16'h0));
    for (int i = 0; i < 4; i++) gen_known[i] = 1'b1;
    drain(400);
    chk("push_total", 64'(dut_log.size()), 64'(8));
    chk("first_pop_edge", 64'(pop_log[0]), 64'(first_allowed));
    for (int i = 0; i < 4; i++)
      chk("read_order", 64'(dut_log[4 + i]), 64'({1'b0, 24'(i), 16'(i)}));

    // single read: push exactly L+3 = 6 edges after pop
    n0 = pop_log.size();
    reqq.push_back(mk(1'b0, 24'h000002, 16'h0));
    drain(100);
    chk("pop_to_push", 64'(push_log[n0] - pop_log[n0]), 64'(6));
    last = dut_log[$];
    chk("read2_data", 64'(last[15:0]), 64'(16'h0002));

    // back-pressure held in RESP for 10 cycles
    full_mode = 1;
    reqq.push_back(mk(1'b0, 24'h000003, 16'h0));
    n = 0;
    while (!(inflight && (cyc - pop_edge) >= L + 2) && n < 50) begin
      tick();
      n++;
    end
    c0 = dut_log.size();
    repeat (10) begin
      tick();
      chk("hold_state", 64'(st), 64'(3));
    end
    chk("hold_nopush", 64'(dut_log.size()), 64'(c0));
    full_mode = 0;
    tick();
    tick();
    chk("release_push", 64'(dut_log.size()), 64'(c0 + 1));
    drain(100);

    // aliasing: 0x400 maps onto 0x000
    reqq.push_back(mk(1'b1, 24'h000400, 16'hBEEF));
    reqq.push_back(mk(1'b0, 24'h000000, 16'h0));
    drain(200);
    last = dut_log[$];
    chk("alias_data", 64'(last[15:0]), 64'(16'hBEEF));
    chk("alias_addr", 64'(last[39:16]), 64'(24'h000000));

    // reset while the request sits in WAIT
    reqq.push_back(mk(1'b0, 24'h000001, 16'h0));
    n = 0;
    while (!inflight && n < 50) begin
      tick();
      n++;
    end
    tick();
    c0 = dut_log.size();
    rst_n = 1'b0;
    inflight = 1'b0;
    exp_data = '0;
    exp_cnt = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    first_allowed = cyc + 2;
    repeat (12) tick();
    chk("rst_nopush", 64'(dut_log.size()), 64'(c0));
    chk("rst_cnt_zero", 64'(cnt), 64'(0));

    reqq.push_back(mk(1'b0, 24'h000001, 16'h0));
    drain(100);
    last = dut_log[$];
    chk("post_rst_data", 64'(last[15:0]), 64'(16'h0001));

    // three requests preloaded back-to-back
    n0 = pop_log.size();
    c0 = dut_log.size();
    reqq.push_back(mk(1'b1, 24'h000005, 16'h1234));
    reqq.push_back(mk(1'b0, 24'h000005, 16'h0));
    reqq.push_back(mk(1'b0, 24'h000002, 16'h0));
    gen_known[5] = 1'b1;
    drain(200);
    chk("b2b_pops", 64'(pop_log.size() - n0), 64'(3));
    chk("b2b_pushes", 64'(dut_log.size() - c0), 64'(3));
    chk("b2b_count", 64'(cnt), 64'(4));
    last = dut_log[c0 + 1];
    chk("b2b_rd_data", 64'(last[15:0]), 64'(16'h1234));

    // random traffic with random back-pressure and aliasing
    full_mode = 2;
    for (int i = 0; i < 150; i++) begin
      op  = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 31));
      hi  = $urandom;
      if (!op && !gen_known[idx]) op = 1'b1;
      if (op) gen_known[idx] = 1'b1;
      reqq.push_back(mk(op, {hi[13:0], 10'(idx)}, 16'($urandom)));
      repeat ($urandom_range(0, 6)) tick();
    end
    drain(6000);
    full_mode = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
